vram_read_arbiter: RTL and testbench

//   Shares the single read port of the tile/sprite video RAM between NUM_REQ requesters.

---
 rtl/vram_read_arbiter_if.sv | 27 ++
 rtl/vram_read_arbiter.sv | 98 +++++++++
 tb/tb_vram_read_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_read_arbiter_if.sv
// Bundle of requester-side and VRAM-side signals of the VRAM read arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface vram_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;

    modport master (
        output req, addr, mem_rdata,
        input  gnt, rvalid, rdata, mem_rd, mem_addr, busy
    );

    modport slave (
        input  req, addr, mem_rdata,
        output gnt, rvalid, rdata, mem_rd, mem_addr, busy
    );
endinterface

// File: rtl/vram_read_arbiter.sv
// Shares the VRAM read port: port 0 (scanline fetch) has absolute priority,
// ports 1..NUM_REQ-1 rotate round-robin. Read data returns in grant order.
module vram_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    vram_read_arbiter_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int RR_N = NUM_REQ - 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic               found_s;
    logic [ID_W-1:0]    win_s;
    logic [ID_W-1:0]    cand_s;
    logic [ID_W-1:0]    rr_next_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ADDR_W-1:0]  addr_a_s [NUM_REQ];
    logic [MEM_LATENCY:0] pipe_valid_r;
    logic [ID_W-1:0]    pipe_id_r [0:MEM_LATENCY];

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [ID_W-1:0] id);
        return ONE_HOT_0 << id;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_a_s[g] = bus.addr[g*ADDR_W +: ADDR_W];
    end

    // Fixed priority for port 0, otherwise first requester at or after rr_ptr_r.
    always_comb begin
        found_s   = 1'b0;
        win_s     = '0;
        cand_s    = '0;
        rr_next_s = ID_W'(1);
        if (bus.req[0]) begin
            found_s = 1'b1;
            win_s   = '0;
        end else begin
            for (int k = 0; k < RR_N; k++) begin
                cand_s = ID_W'(((int'(rr_ptr_r) - 1 + k) % RR_N) + 1);
                if (!found_s && bus.req[cand_s]) begin
                    found_s = 1'b1;
                    win_s   = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end
        if (win_s == ID_W'(RR_N)) begin
            rr_next_s = ID_W'(1);
        end else begin
            rr_next_s = win_s + ID_W'(1);
        end
    end

    // Grant/issue registers, rotation pointer and the {valid,id} return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gnt      <= '0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
            bus.rvalid   <= '0;
            bus.rdata    <= '0;
            rr_ptr_r     <= ID_W'(1);
            pipe_valid_r <= '0;
            for (int k = 0; k <= MEM_LATENCY; k++) begin
                pipe_id_r[k] <= '0;
            end
        end else begin
            bus.gnt    <= found_s ? one_hot(win_s) : '0;
            bus.mem_rd <= found_s;
            if (found_s) begin
                bus.mem_addr <= addr_a_s[win_s];
            end
            // A port-0 grant does not move the rotation.
            if (found_s && (win_s != '0)) begin
                rr_ptr_r <= rr_next_s;
            end
            pipe_valid_r <= {pipe_valid_r[MEM_LATENCY-1:0], found_s};
            pipe_id_r[0] <= win_s;
            for (int k = 1; k <= MEM_LATENCY; k++) begin
                pipe_id_r[k] <= pipe_id_r[k-1];
            end
            bus.rvalid <= pipe_valid_r[MEM_LATENCY] ? one_hot(pipe_id_r[MEM_LATENCY]) : '0;
            if (pipe_valid_r[MEM_LATENCY]) begin
                bus.rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.busy = |pipe_valid_r;

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Scoreboard bench for vram_read_arbiter: a behavioural model predicts grants and
// read returns; a separate monitor compares what the DUT presents every cycle.
module tb_vram_read_arbiter;
    localparam int N = 4;
    localparam int A = 12;
    localparam int D = 8;
    localparam int L = 2;

    typedef struct {
        logic [N-1:0] gnt;
        logic         rd;
        logic [A-1:0] maddr;
        logic         rs;
    } gexp_t;

    typedef struct {
        int           id;
        logic [D-1:0] data;
        int           due;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(A), .DATA_W(D)) bus ();

    vram_read_arbiter #(.NUM_REQ(N), .ADDR_W(A), .DATA_W(D), .MEM_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    gexp_t gq[$];
    rexp_t rq[$];
    int    order[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    n_edge = 0;
    logic [A-1:0] exp_maddr = '0;

    function automatic logic [D-1:0] mem_fn(input logic [A-1:0] a);
        return D'(a) ^ D'(a >> 4) ^ 8'hA5;
    endfunction

    // Memory model: returns mem_fn(addr) L cycles after a read strobe, junk otherwise.
    logic [A-1:0] ahist [L];
    logic [L-1:0] rhist = '0;
    logic [D-1:0] junk = '0;
    always @(posedge clk) begin
        ahist[0] <= bus.mem_addr;
        for (int k = 1; k < L; k++) ahist[k] <= ahist[k-1];
        rhist <= {rhist[L-2:0], bus.mem_rd};
        junk  <= D'($urandom);
    end
    assign bus.mem_rdata = rhist[L-1] ? mem_fn(ahist[L-1]) : junk;

    task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, e, act, exp);
        end
    endtask

    function automatic void rr_reset();
        order.delete();
        for (int i = 1; i < N; i++) order.push_back(i);
    endfunction

    function automatic int pick(input logic [N-1:0] r);
        if (r[0]) return 0;
        foreach (order[j]) begin
            if (((int'(r) >> order[j]) & 1) == 1) return order[j];
        end
        return -1;
    endfunction

    function automatic logic [N*A-1:0] rand_addrs();
        return (N*A)'({$urandom(), $urandom()});
    endfunction

    // Apply one cycle of stimulus, predict its outcome, advance to the next cycle.
    task automatic step(input logic [N-1:0] r, input logic [N*A-1:0] a, input logic rs, output int w);
        int nxt;
        bus.req  = r;
        bus.addr = a;
        rst      = rs;
        w        = -1;
        if (rs) begin
            rr_reset();
            rq.delete();
            exp_maddr = '0;
            gq.push_back('{gnt: '0, rd: 1'b0, maddr: '0, rs: 1'b1});
        end else begin
            w = pick(r);
            if (w >= 0) begin
                exp_maddr = A'(a >> (w * A));
                rq.push_back('{id: w, data: mem_fn(exp_maddr), due: n_edge + L + 1});
                if (w != 0) begin
                    nxt = (w == N - 1) ? 1 : w + 1;
                    while (order[0] != nxt) order.push_back(order.pop_front());
                end
                gq.push_back('{gnt: N'(32'd1 << w), rd: 1'b1, maddr: exp_maddr, rs: 1'b0});
            end else begin
                gq.push_back('{gnt: '0, rd: 1'b0, maddr: exp_maddr, rs: 1'b0});
            end
        end
        @(negedge clk);
        n_edge++;
    endtask

    // Monitor: one sample per rising edge, 1 time unit after it.
    initial begin
        int    e;
        gexp_t g;
        rexp_t x;
        e = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL no_expectation edge=%0d actual=none required=entry", e);
            end else begin
                g = gq.pop_front();
                chk("gnt", e, 32'(bus.gnt), 32'(g.gnt));
                chk("mem_rd", e, 32'(bus.mem_rd), 32'(g.rd));
                chk("mem_addr", e, 32'(bus.mem_addr), 32'(g.maddr));
                if (g.rs) chk("rdata_reset", e, 32'(bus.rdata), 32'd0);
            end
            while (rq.size() > 0 && rq[0].due < e) begin
                x = rq.pop_front();
                chk("rvalid_missing", e, 32'(bus.rvalid), 32'(N'(32'd1 << x.id)));
            end
            if (rq.size() > 0 && rq[0].due == e) begin
                x = rq.pop_front();
                chk("rvalid", e, 32'(bus.rvalid), 32'(N'(32'd1 << x.id)));
                chk("rdata", e, 32'(bus.rdata), 32'(x.data));
            end else begin
                chk("rvalid_idle", e, 32'(bus.rvalid), 32'd0);
            end
            chk("busy", e, 32'(bus.busy), 32'(rq.size() > 0));
            e++;
        end
    end

    initial begin
        int           w;
        int           last_w;
        int           pend_a [N];
        logic [A-1:0] addr_a [N];
        logic [N-1:0] pv;
        logic [N*A-1:0] av;
        rr_reset();
        bus.req  = '0;
        bus.addr = '0;

        for (int i = 0; i < 3; i++) step('0, '0, 1'b1, w);
        // T1: idle after reset
        for (int i = 0; i < 20; i++) step('0, rand_addrs(), 1'b0, w);
        // T2: single request on port 2 at 0x123
        step(4'b0100, (N*A)'(12'h123) << (2 * A), 1'b0, w);
        for (int i = 0; i < 5; i++) step('0, '0, 1'b0, w);
        // T3: ports 1..3 held, rotation wraps after port 3
        for (int i = 0; i < 12; i++) step(4'b1110, rand_addrs(), 1'b0, w);
        // T4: all ports for 5 cycles, then port 0 drops
        for (int i = 0; i < 5; i++) step(4'b1111, rand_addrs(), 1'b0, w);
        for (int i = 0; i < 6; i++) step(4'b1110, rand_addrs(), 1'b0, w);
        for (int i = 0; i < 5; i++) step('0, '0, 1'b0, w);

        // T5: random requesters that hold req/addr until granted
        last_w = -1;
        for (int i = 0; i < N; i++) begin
            pend_a[i] = 0;
            addr_a[i] = '0;
        end
        for (int c = 0; c < 1000; c++) begin
            pv = '0;
            av = '0;
            for (int i = 0; i < N; i++) begin
                if (pend_a[i] == 0 || last_w == i) begin
                    pend_a[i] = ($urandom_range(0, 99) < ((i == 0) ? 25 : 45)) ? 1 : 0;
                    addr_a[i] = A'($urandom);
                end
                if (pend_a[i] != 0) pv = pv | N'(32'd1 << i);
                av = av | ((N*A)'(addr_a[i]) << (i * A));
            end
            step(pv, av, 1'b0, w);
            last_w = w;
        end
        for (int i = 0; i < 6; i++) step('0, '0, 1'b0, w);

        // T6: reset one cycle after a grant to port 1 discards the read
        step(4'b0010, rand_addrs(), 1'b0, w);
        step('0, '0, 1'b1, w);
        for (int i = 0; i < 8; i++) step('0, '0, 1'b0, w);

        chk("rv_queue_empty", n_edge, 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
